uart_tx: RTL

//  Serialises bytes from an AXI-Stream slave port onto a UART TX line:
//  8 data bits LSB first, 1 start bit, STOP_BITS stop bits, no parity.
//  It is the transmit counterpart of the UART receiver; the two share

---
 rtl/uart_tx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: AXI-Stream byte in, 8N1 (1 or 2 stop bits) UART frame out.
// A one-entry holding register lets the next byte wait while a frame shifts.
// Ports:
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_s_axis_tvalid  byte available
//   i_s_axis_tdata   byte to send, bit 0 first
//   o_s_axis_tready  holding register empty
//   o_txd            serial line, idle high, registered
//   o_txd_busy       frame shifting or byte held
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_s_axis_tvalid,
    input  logic [7:0] i_s_axis_tdata,
    output logic       o_s_axis_tready,
    output logic       o_txd,
    output logic       o_txd_busy
);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic            txd_q, txd_d;
    logic            load;
    logic            unload;
    logic            cnt_last;

    assign load     = i_s_axis_tvalid & ~hold_full_q;
    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unload  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    unload  = 1'b1;
                    shift_d = hold_q;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                // bit_q counts stop bits here
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (hold_full_q) begin
                            unload  = 1'b1;
                            shift_d = hold_q;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // load needs empty, unload needs full: never both in one cycle
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (load) begin
            hold_d      = i_s_axis_tdata;
            hold_full_d = 1'b1;
        end else if (unload) begin
            hold_full_d = 1'b0;
        end
    end

    // line level derived from next state so o_txd is a plain flop
    always_comb begin
        txd_d = 1'b1;
        unique case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[bit_d];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            txd_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            txd_q       <= txd_d;
        end
    end

    assign o_s_axis_tready = ~hold_full_q;
    assign o_txd           = txd_q;
    assign o_txd_busy      = (state_q != IDLE) | hold_full_q;

endmodule
